// File: rtl/buf_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | buf_arb_pkg : shared types/constants for buffer read-port arbitration     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package buf_arb_pkg;

  localparam int c_buf_rd_lat_dflt = 4;
  // Wide enough for the largest supported requester count (8).
  localparam int c_tag_id_w = 3;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                  vld;
    logic [c_tag_id_w-1:0] id;
  } rd_tag_t;

  typedef logic [31:0] stat_cnt_t;
  localparam stat_cnt_t c_stat_cnt_max = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter : combinational one-hot round-robin grant, registered pointer |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module rr_arbiter
  import buf_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  logic [IDX_W-1:0] r_ptr;

  always_comb begin
    int unsigned j;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_any && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
        gnt_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (gnt_any) begin
      r_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/buffer_rd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | buffer_rd_arbiter : round-robin sharing of a feature-buffer read port,   |
// | tags reads through the fixed buffer latency and routes data back.        |
// | Optional: BUF_RD_ARB_STATS_EN adds saturating grant/stall counters.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module buffer_rd_arbiter
  import buf_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 512,
  parameter int BUF_RD_LAT = c_buf_rd_lat_dflt
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      buf_rd_addr_valid,
  output logic [ADDR_W-1:0]         buf_rd_addr,
  input  logic                      buf_rd_data_valid,
  input  logic [DATA_W-1:0]         buf_rd_data,
`ifdef BUF_RD_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]     stat_grant_cnt,
  output logic [NUM_REQ*32-1:0]     stat_stall_cnt,
`endif
  output logic                      err_unexp_rsp
);

  localparam int IDX_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_gnt_any;
  logic [ADDR_W-1:0]     w_gnt_addr;
  logic [c_tag_id_w-1:0] r_issue_id;
  rd_tag_t               r_tag [BUF_RD_LAT];
  rd_tag_t               w_tail;
  logic [NUM_REQ-1:0]    w_rsp_hot;
  logic                  w_rsp_take;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  assign req_ready = w_gnt;

  always_comb begin
    w_gnt_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_rd_addr_valid <= 1'b0;
      buf_rd_addr       <= '0;
      r_issue_id        <= '0;
    end else begin
      buf_rd_addr_valid <= w_gnt_any;
      buf_rd_addr       <= w_gnt_any ? w_gnt_addr : '0;
      r_issue_id        <= w_gnt_any ? c_tag_id_w'(w_gnt_idx) : '0;
    end
  end

  // Loaded from the issue register so the tail lines up with data_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{vld: buf_rd_addr_valid, id: r_issue_id};
      for (int i = 1; i < BUF_RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tail     = r_tag[BUF_RD_LAT-1];
  assign w_rsp_take = buf_rd_data_valid & w_tail.vld;

  always_comb begin
    w_rsp_hot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rsp_hot[i] = w_rsp_take && (w_tail.id == c_tag_id_w'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid     <= '0;
      rsp_data      <= '0;
      err_unexp_rsp <= 1'b0;
    end else begin
      rsp_valid <= w_rsp_hot;
      rsp_data  <= w_rsp_take ? buf_rd_data : '0;
      if (buf_rd_data_valid ^ w_tail.vld) err_unexp_rsp <= 1'b1;
    end
  end

`ifdef BUF_RD_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    stat_cnt_t r_gcnt;
    stat_cnt_t r_scnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_gcnt <= '0;
        r_scnt <= '0;
      end else begin
        if (w_gnt[i] && (r_gcnt != c_stat_cnt_max)) r_gcnt <= r_gcnt + 1'b1;
        if (req_valid[i] && !w_gnt[i] && (r_scnt != c_stat_cnt_max))
          r_scnt <= r_scnt + 1'b1;
      end
    end

    assign stat_grant_cnt[i*32 +: 32] = r_gcnt;
    assign stat_stall_cnt[i*32 +: 32] = r_scnt;
  end
`endif

endmodule
`default_nettype wire

// File: doc/buffer_rd_arbiter.md
Name: buffer_rd_arbiter

Overview:
- Shares the single read port of an on-chip feature buffer (2-cycle-latency SDP RAM, 4-cycle total read latency) among NUM_REQ requesters (agg, save, debug readback).
- Round-robin arbitration with a per-cycle valid/ready handshake. Issues at most one registered read per cycle.
- Tracks requester IDs through the buffer's fixed read latency and routes each returned word to its originator.
- Sits between the requester engines and the buffer read port (addr_valid/addr in, data_valid/data out).

Parameters:
- NUM_REQ, 3, number of read requesters (2..8).
- ADDR_W, 11, buffer address width.
- DATA_W, 512, buffer data width.
- BUF_RD_LAT, 4, cycles from buf_rd_addr_valid sampled high to buf_rd_data_valid high.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  grant; a transfer occurs on valid&ready.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_data  out  DATA_W  response data, shared by all requesters.
- buf_rd_addr_valid  out  1  to buffer read-address valid.
- buf_rd_addr  out  ADDR_W  to buffer read address.
- buf_rd_data_valid  in  1  from buffer.
- buf_rd_data  in  DATA_W  from buffer.
- err_unexp_rsp  out  1  sticky: buffer data arrived with no matching tag.

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; tag pipeline empty; err_unexp_rsp=0.
- req_ready is combinational from req_valid and rr_ptr.
  - Search starts at index rr_ptr and wraps modulo NUM_REQ; the first asserted req_valid wins.
  - At most one bit is set; req_ready is 0 when no request is valid.
- Requester rules:
  - A requester holds req_valid and req_addr stable until ready.
  - req_valid may drop without a grant; it is never granted on a later cycle.
- On a grant to index g: rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Issue stage, registered: the cycle after a grant, buf_rd_addr_valid=1 and buf_rd_addr = the granted address. Otherwise valid=0 and addr=0.
- Tag pipeline:
  - BUF_RD_LAT-deep shift register of {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Loaded in step with buf_rd_addr_valid and shifted every cycle.
  - Its tail aligns with buf_rd_data_valid.
- Response stage, registered: the cycle after buf_rd_data_valid with tail valid:
  - rsp_valid[tail_id]=1 and rsp_data=buf_rd_data.
  - Otherwise rsp_valid=0 and rsp_data=0.
- End-to-end latency: handshake cycle T, then rsp_valid at T+BUF_RD_LAT+2 (6 with defaults). Throughput is 1 read per cycle, with back-to-back grants to any mix of requesters.
- Ordering: responses return in grant order. Per-requester order is preserved.
- Error cases, both set err_unexp_rsp (cleared only by reset):
  - buf_rd_data_valid=1 with tail invalid: the response is dropped.
  - Tail valid with buf_rd_data_valid=0: the response is lost.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,... Every requester is served within NUM_REQ cycles.
- Reset mid-operation: the tag pipeline, issue stage and response stage clear asynchronously. In-flight reads are discarded, because the buffer shares rst_n and discards them too. The first grant after release comes from index 0.
- Single-requester case: a continuously valid requester is granted every cycle.

Optional Feature:
- Macro: BUF_RD_ARB_STATS_EN.
- When defined, adds these outputs:
  - stat_grant_cnt, NUM_REQ*32: per-requester grant count.
  - stat_stall_cnt, NUM_REQ*32: cycles with valid&!ready per requester.
- Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package buf_arb_pkg:
  - ID width function and default latency constant.
  - Typedef rd_tag_t {logic vld; logic [ID_W-1:0] id;}.
  - Typedef stat_cnt_t (32-bit).
- Sub-module rr_arbiter (NUM_REQ): combinational one-hot grant plus registered rr_ptr update. It is reused by future write-port sharing.

Test Plan:
- Single request: req0 at 0x123 against a buffer model holding 0x123 -> data D; expect buf_rd_addr=0x123 one cycle later and rsp_valid=3'b001 with rsp_data=D 6 cycles after the handshake.
- All three requesters valid for 9 cycles -> grants 0,1,2,0,1,2,0,1,2; responses arrive in the same order with the correct addresses' data; no gaps.
- Requester 1 only, valid for 16 cycles with addr 0..15 -> 16 consecutive rsp_valid=3'b010 with data for 0..15, no bubbles.
- req2 drops valid before a grant while req0 is granted -> no read is issued for req2; rr_ptr is 1 afterwards.
- Assert rst_n=0 with 3 reads in flight, then release -> no rsp_valid ever appears for them and err_unexp_rsp stays 0.
- Inject buf_rd_data_valid with an empty pipeline -> err_unexp_rsp=1 on the next cycle and stays 1; no rsp_valid. With STATS_EN, check stat_stall_cnt for req2=2 in the fairness test's first cycles.
